stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the combinational 32:1 bit mux.
- Merges N valid/ready input streams of W-bit words onto one registered output stream.
- Selects the source by round-robin or fixed-priority arbitration, and reports which channel each output word came from.
- Sits between multiple producers (register-file read ports, peripheral buses) and a single consumer.

Parameters:
- N, 32, number of input channels; any N >= 2, need not be a power of two.
- W, 32, data width per channel.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- SEL_W, $clog2(N), width of channel index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  flattened input words; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high in any cycle.
- out_data  output  W  registered output word.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer ready.
- out_sel  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the clk rising edge.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is all-zero while rst=1.
- Output buffer state machine (one-entry output register):
  - EMPTY (out_valid=0):
    - If any in_valid is high, the granted channel g gets in_ready[g]=1.
    - Transfer occurs; next state is FULL, with out_data=in_data[g], out_sel=g.
  - FULL (out_valid=1):
    - If out_ready=1, the word drains.
    - In the same cycle a new grant may load, giving FULL->FULL with new data; throughput is 1 word/cycle.
    - If out_ready=1 and no in_valid is high, next state is EMPTY.
    - If out_ready=0: all in_ready=0, and out_data/out_sel/out_valid are held stable.
- Accept condition: can_load = !out_valid | out_ready. in_ready[g] = can_load & in_valid[g] & grant[g].
  - in_ready depends combinationally on out_ready and in_valid.
  - in_ready never depends combinationally on itself.
- Latency: word accepted in cycle t appears on out_data with out_valid=1 in cycle t+1.
- Round-robin grant (ARB_MODE=0):
  - Search starts at index ptr and proceeds upward with wrap; the first valid channel wins.
  - ptr updates only on an actual transfer: ptr <= (g==N-1) ? 0 : g+1.
- Fixed priority (ARB_MODE=1): the lowest-index valid channel wins; ptr is unused and held at 0.
- Boundary conditions:
  - No valid inputs: no grant, all in_ready=0, ptr unchanged.
  - Single valid channel: it receives every slot regardless of ptr.
  - ptr is never >= N, including for non-power-of-two N.
  - in_valid dropping before acceptance (protocol violation by source): no transfer, no ptr update.
  - Source contract: valid held with data stable until accepted.
  - Reset mid-operation: a buffered word is discarded. The next cycle shows out_valid=0 and ptr=0, and no in_ready is issued during rst.
  - Simultaneous drain and load: exactly one word leaves and one enters; out_valid stays 1.

Decomposition:
- Package stream_mux_pkg holds:
  - arb_mode_t enum: ARB_RR=0, ARB_FIXED=1.
  - Helper function next_ptr(g, N) for the wrap increment.
- Sub-module rr_arbiter:
  - Parameters N, ARB_MODE.
  - Inputs clk, rst, req[N], advance.
  - Outputs grant[N] (one-hot), grant_idx[SEL_W].
  - It owns ptr. stream_mux_rr owns the output register, the handshake, and the data select; the data select is an indexed part-select by grant_idx.

Test Plan:
- Reset: hold rst 2 cycles with all in_valid=1 -> in_ready=0 throughout; after release, out_valid=0 and out_sel=0; the first grant goes to channel 0.
- Single beat: N=32, W=32; in_valid[5]=1, in_data ch5=0xDEADBEEF, out_ready=1 -> in_ready[5]=1 in cycle t; in cycle t+1, out_valid=1, out_data=0xDEADBEEF, out_sel=5.
- Round-robin fairness with wrap: channels 0, 3 and 31 valid continuously, out_ready=1 -> out_sel sequence 0,3,31,0,3,31. One transfer per cycle, no bubbles.
- Backpressure: output FULL with 0x0000_00AA from ch2, out_ready=0 for 4 cycles with ch7 valid:
  - During the stall: in_ready all 0, out_data and out_sel stable.
  - On out_ready=1: 0xAA drains and ch7 loads in the same cycle.
- Fixed priority (ARB_MODE=1): channels 2 and 7 valid -> out_sel=2 on every beat. Drop ch2 -> the next beat shows out_sel=7.
- Reset mid-stream: assert rst while out_valid=1 and ptr=4, with channels 1 and 6 valid -> the next cycle shows out_valid=0; after release, the first grant is channel 1.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

  // Arbitration policy selector.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // One-entry output buffer occupancy.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Pointer increment with wrap at n (works for non-power-of-two n).
  function automatic int next_ptr(input int g, input int n);
    if (g >= n - 32'sd1) begin
      return 32'sd0;
    end else begin
      return g + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin / fixed-priority arbiter. Owns the round-robin pointer; the
// grant is combinational from req and the pointer.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N        = 32,
  parameter int ARB_MODE = 0,
  localparam int SEL_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W-1:0] ptr_r;
  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] idx_s;
  logic             found_s;
  int               base_s;
  int               cand_s;

  // Search upward from the start index with wrap; first requester wins.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    cand_s  = 32'sd0;
    if (ARB_MODE == int'(ARB_FIXED)) begin
      base_s = 32'sd0;
    end else begin
      base_s = int'(ptr_r);
    end
    for (int k = 0; k < N; k++) begin
      cand_s = base_s + k;
      if (cand_s >= N) begin
        cand_s = cand_s - N;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s]) begin
        found_s         = 1'b1;
        grant_s[cand_s] = 1'b1;
        idx_s           = SEL_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves past the winner only when a transfer actually happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (advance && (ARB_MODE == int'(ARB_RR))) begin
      ptr_r <= SEL_W'(next_ptr(int'(idx_s), N));
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with a one-entry registered output.
// Reports the source channel of each output word on out_sel.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N        = 32,
  parameter int W        = 32,
  parameter int ARB_MODE = 0,
  localparam int SEL_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
);

  buf_state_t       state_r;
  buf_state_t       state_nxt_s;
  logic [W-1:0]     out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic [N-1:0]     in_ready_s;
  logic             can_load_s;
  logic             transfer_s;
  logic [W-1:0]     data_sel_s;

  rr_arbiter #(
    .N        (N),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .advance   (transfer_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign data_sel_s = in_data[int'(grant_idx_s) * W +: W];

  // Handshake and next-state: load when the buffer is empty or draining.
  always_comb begin
    in_ready_s  = '0;
    state_nxt_s = state_r;
    can_load_s  = (state_r == BUF_EMPTY) || out_ready;
    if (!rst && can_load_s) begin
      in_ready_s = grant_s;
    end else begin
      in_ready_s = '0;
    end
    transfer_s = |in_ready_s;
    case (state_r)
      BUF_EMPTY: begin
        if (transfer_s) begin
          state_nxt_s = BUF_FULL;
        end else begin
          state_nxt_s = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (transfer_s) begin
          state_nxt_s = BUF_FULL;
        end else if (out_ready) begin
          state_nxt_s = BUF_EMPTY;
        end else begin
          state_nxt_s = BUF_FULL;
        end
      end
      default: begin
        state_nxt_s = BUF_EMPTY;
      end
    endcase
  end

  // Output register: capture the granted word, otherwise hold stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= BUF_EMPTY;
      out_data_r <= '0;
      out_sel_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (transfer_s) begin
        out_data_r <= data_sel_s;
        out_sel_r  <= grant_idx_s;
      end else begin
        out_data_r <= out_data_r;
        out_sel_r  <= out_sel_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = (state_r == BUF_FULL);
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: one round-robin and one fixed-priority
// instance, hand-computed expectations checked with immediate assertions.
module tb_stream_mux_rr;

  localparam int N = 32;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [4:0]     out_sel;

  logic [N*W-1:0] fx_data;
  logic [N-1:0]   fx_valid;
  logic [N-1:0]   fx_in_ready;
  logic [W-1:0]   fx_out_data;
  logic           fx_out_valid;
  logic           fx_ready;
  logic [4:0]     fx_sel;

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.N(N), .W(W), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel)
  );

  stream_mux_rr #(.N(N), .W(W), .ARB_MODE(1)) dut_fx (
    .clk(clk), .rst(rst), .in_data(fx_data), .in_valid(fx_valid),
    .in_ready(fx_in_ready), .out_data(fx_out_data), .out_valid(fx_out_valid),
    .out_ready(fx_ready), .out_sel(fx_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_sel [6];
    exp_sel = '{0, 3, 31, 0, 3, 31};

    rst       = 1'b1;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    fx_valid  = '0;
    fx_data   = '0;
    fx_ready  = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000_0000 + 32'(i);

    // Reset held two cycles with every channel valid.
    @(negedge clk);
    check("rst_ready_0", 64'(in_ready), 64'h0);
    @(negedge clk);
    check("rst_ready_1", 64'(in_ready), 64'h0);
    rst      = 1'b0;
    in_valid = '0;
    tick();
    check("post_rst_valid", 64'(out_valid), 64'h0);
    check("post_rst_sel", 64'(out_sel), 64'h0);
    check("post_rst_data", 64'(out_data), 64'h0);

    // First grant is channel 0; valid then withdrawn before the edge.
    in_valid = '1;
    #1;
    check("first_grant", 64'(in_ready), 64'h1);
    in_valid = '0;
    #1;
    check("idle_ready", 64'(in_ready), 64'h0);
    tick();
    check("dropped_no_xfer", 64'(out_valid), 64'h0);

    // Round robin over channels 0, 3, 31 with wrap and no bubbles.
    in_valid = 32'h8000_0009;
    #1;
    check("rr_first_ready", 64'(in_ready), 64'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("rr_valid", 64'(out_valid), 64'h1);
      check("rr_sel", 64'(out_sel), 64'(exp_sel[k]));
    end
    check("rr_last_data", 64'(out_data), 64'h1000_001F);

    // Single beat from channel 5 while the previous word drains.
    in_valid = 32'h0000_0020;
    in_data[5*W +: W] = 32'hDEAD_BEEF;
    #1;
    check("beat_ready", 64'(in_ready), 64'h20);
    tick();
    check("beat_valid", 64'(out_valid), 64'h1);
    check("beat_data", 64'(out_data), 64'hDEAD_BEEF);
    check("beat_sel", 64'(out_sel), 64'd5);
    in_valid = '0;
    tick();
    check("drain_empty", 64'(out_valid), 64'h0);

    // Backpressure: 0xAA from channel 2 held while channel 7 waits.
    in_valid = 32'h0000_0004;
    in_data[2*W +: W] = 32'h0000_00AA;
    tick();
    in_valid = 32'h0000_0080;
    in_data[7*W +: W] = 32'h0000_0077;
    out_ready = 1'b0;
    #1;
    check("bp_ready_0", 64'(in_ready), 64'h0);
    check("bp_data", 64'(out_data), 64'hAA);
    check("bp_sel", 64'(out_sel), 64'd2);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("stall_ready", 64'(in_ready), 64'h0);
      check("stall_valid", 64'(out_valid), 64'h1);
      check("stall_data", 64'(out_data), 64'hAA);
      check("stall_sel", 64'(out_sel), 64'd2);
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready), 64'h80);
    tick();
    check("swap_valid", 64'(out_valid), 64'h1);
    check("swap_data", 64'(out_data), 64'h77);
    check("swap_sel", 64'(out_sel), 64'd7);

    // Move ptr to 4 via channel 3, then reset with channels 1 and 6 valid.
    in_valid = 32'h0000_0008;
    tick();
    check("ch3_sel", 64'(out_sel), 64'd3);
    in_valid = 32'h0000_0042;
    #1;
    check("ptr4_grant", 64'(in_ready), 64'h40);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 64'(in_ready), 64'h0);
    tick();
    check("rst_mid_valid", 64'(out_valid), 64'h0);
    check("rst_mid_sel", 64'(out_sel), 64'h0);
    rst = 1'b0;
    #1;
    check("rst_mid_grant", 64'(in_ready), 64'h2);
    tick();
    check("rst_mid_out", 64'(out_sel), 64'd1);
    in_valid = '0;

    // Fixed priority: channel 2 beats 7 every time, then 7 once 2 drops.
    fx_valid = 32'h0000_0084;
    fx_data[2*W +: W] = 32'h0000_0222;
    fx_data[7*W +: W] = 32'h0000_0777;
    #1;
    check("fx_ready", 64'(fx_in_ready), 64'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fx_sel2", 64'(fx_sel), 64'd2);
      check("fx_data2", 64'(fx_out_data), 64'h222);
    end
    fx_valid = 32'h0000_0080;
    tick();
    check("fx_sel7", 64'(fx_sel), 64'd7);
    check("fx_valid7", 64'(fx_out_valid), 64'h1);
    fx_valid = '0;
    tick();
    check("fx_empty", 64'(fx_out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
